// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   state_e : arbiter FSM states (IDLE / ACCESS / RESP)
//   port_e  : requester identifier (A = CPU LSU, B = DMA/loader)
//   RW_*    : memory RW encodings
//   MEM_WORDS_DEF : default memory depth in 32-bit words
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned MEM_WORDS_DEF = 1024;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input grant logic with a round-robin pointer register.
//   clk_i, rst_i  : clock, synchronous active-high reset (pointer -> A)
//   req_a_i/b_i   : eligible requests
//   update_i      : a grant taken this cycle advances the pointer
//   gnt_o         : some request is granted
//   gnt_port_o    : which port wins
// FIXED_PRI=1 makes A win every contention; the pointer is then ignored.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  req_a_i,
    input  logic  req_b_i,
    input  logic  update_i,
    output logic  gnt_o,
    output port_e gnt_port_o
);

    port_e ptr_q, ptr_d;

    always_comb begin
        gnt_o      = req_a_i | req_b_i;
        gnt_port_o = PORT_A;
        if (req_a_i && req_b_i) begin
            gnt_port_o = FIXED_PRI ? PORT_A : ptr_q;
        end else if (req_b_i) begin
            gnt_port_o = PORT_B;
        end
    end

    // After a grant the pointer names the port that lost (or did not ask).
    always_comb begin
        ptr_d = ptr_q;
        if (update_i && gnt_o) begin
            ptr_d = (gnt_port_o == PORT_A) ? PORT_B : PORT_A;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PORT_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one word-addressed data-memory port between requester A
// (CPU load/store unit) and requester B (DMA/loader).
//   CLK, RST             : clock, synchronous active-high reset
//   A_REQ/ADDR/RW/WD     : A request, byte address, 1=write, write data
//   A_ACK/ERR/RD         : one-cycle done pulse, out-of-range flag, read data
//   B_*                  : same set for requester B
//   MEM_ADDR/RW/WD       : driven only during the ACCESS cycle, else zero
//   MEM_RD               : combinational memory read data
// Each access takes IDLE/RESP -> ACCESS -> RESP(ack); the RESP cycle hands
// the memory straight to the other port if it is requesting.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_REQ,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic              A_RW,
    input  logic [DATA_W-1:0] A_WD,
    output logic              A_ACK,
    output logic              A_ERR,
    output logic [DATA_W-1:0] A_RD,
    input  logic              B_REQ,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic              B_RW,
    input  logic [DATA_W-1:0] B_WD,
    output logic              B_ACK,
    output logic              B_ERR,
    output logic [DATA_W-1:0] B_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RW,
    output logic [DATA_W-1:0] MEM_WD,
    input  logic [DATA_W-1:0] MEM_RD
);

    localparam int unsigned HI_LSB = 2 + $clog2(MEM_WORDS);

    state_e state_q, state_d;
    port_e  gnt_q, gnt_d;

    logic   arb_req_a, arb_req_b, arb_update, arb_gnt;
    port_e  arb_port;

    logic [ADDR_W-1:0] sel_addr;
    logic              sel_rw;
    logic [DATA_W-1:0] sel_wd;
    logic              addr_err;
    logic              in_access;
    logic              done_a, done_b;

    logic              a_ack_q, b_ack_q, a_err_q, b_err_q;
    logic [DATA_W-1:0] a_rd_q, b_rd_q;

    // Only fresh arbitration from IDLE consumes a round-robin turn; the
    // RESP hand-off to the waiting port is forced and leaves the pointer.
    rr_arb2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_arb (
        .clk_i      (CLK),
        .rst_i      (RST),
        .req_a_i    (arb_req_a),
        .req_b_i    (arb_req_b),
        .update_i   (arb_update),
        .gnt_o      (arb_gnt),
        .gnt_port_o (arb_port)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        arb_req_a  = 1'b0;
        arb_req_b  = 1'b0;
        arb_update = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arb_req_a  = A_REQ;
                arb_req_b  = B_REQ;
                arb_update = 1'b1;
                if (arb_gnt) begin
                    gnt_d   = arb_port;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // The port being acked is not eligible; only the other may follow.
                if (gnt_q == PORT_A ? B_REQ : A_REQ) begin
                    gnt_d   = (gnt_q == PORT_A) ? PORT_B : PORT_A;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sel_addr = (gnt_q == PORT_B) ? B_ADDR : A_ADDR;
        sel_rw   = (gnt_q == PORT_B) ? B_RW   : A_RW;
        sel_wd   = (gnt_q == PORT_B) ? B_WD   : A_WD;
    end

    generate
        if (ADDR_W > HI_LSB) begin : g_range
            assign addr_err = |sel_addr[ADDR_W-1:HI_LSB];
        end else begin : g_norange
            assign addr_err = 1'b0;
        end
    endgenerate

    assign in_access = (state_q == ST_ACCESS) && !RST;
    assign MEM_RW    = in_access && (sel_rw == RW_WRITE) && !addr_err;
    assign MEM_ADDR  = in_access ? sel_addr : '0;
    assign MEM_WD    = in_access ? sel_wd   : '0;

    assign done_a = (state_q == ST_ACCESS) && (gnt_q == PORT_A);
    assign done_b = (state_q == ST_ACCESS) && (gnt_q == PORT_B);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= PORT_A;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            a_err_q <= 1'b0;
            b_err_q <= 1'b0;
            a_rd_q  <= '0;
            b_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            a_ack_q <= done_a;
            b_ack_q <= done_b;
            a_err_q <= done_a && addr_err;
            b_err_q <= done_b && addr_err;
            // Writes leave the RD register alone (MEM_RD floats during a write).
            if (done_a) begin
                if (addr_err) begin
                    a_rd_q <= '0;
                end else if (sel_rw == RW_READ) begin
                    a_rd_q <= MEM_RD;
                end
            end
            if (done_b) begin
                if (addr_err) begin
                    b_rd_q <= '0;
                end else if (sel_rw == RW_READ) begin
                    b_rd_q <= MEM_RD;
                end
            end
        end
    end

    assign A_ACK = a_ack_q;
    assign A_ERR = a_err_q;
    assign A_RD  = a_rd_q;
    assign B_ACK = b_ack_q;
    assign B_ERR = b_err_q;
    assign B_RD  = b_rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        A_REQ = 1'b0, B_REQ = 1'b0;
    logic [31:0] A_ADDR = '0, B_ADDR = '0, A_WD = '0, B_WD = '0;
    logic        A_RW = 1'b0, B_RW = 1'b0;
    logic        A_ACK, A_ERR, B_ACK, B_ERR;
    logic [31:0] A_RD, B_RD, MEM_ADDR, MEM_WD, MEM_RD;
    logic        MEM_RW;

    // Second instance with fixed priority, on its own signals.
    logic        fA_REQ = 1'b0, fB_REQ = 1'b0;
    logic [31:0] fA_ADDR = '0, fB_ADDR = '0;
    logic        fA_ACK, fA_ERR, fB_ACK, fB_ERR, fMEM_RW;
    logic [31:0] fA_RD, fB_RD, fMEM_ADDR, fMEM_WD;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(1024), .FIXED_PRI(1'b0)) u_dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_RW(A_RW), .A_WD(A_WD),
        .A_ACK(A_ACK), .A_ERR(A_ERR), .A_RD(A_RD),
        .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_RW(B_RW), .B_WD(B_WD),
        .B_ACK(B_ACK), .B_ERR(B_ERR), .B_RD(B_RD),
        .MEM_ADDR(MEM_ADDR), .MEM_RW(MEM_RW), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(1024), .FIXED_PRI(1'b1)) u_fix (
        .CLK(CLK), .RST(RST),
        .A_REQ(fA_REQ), .A_ADDR(fA_ADDR), .A_RW(1'b0), .A_WD(32'h0),
        .A_ACK(fA_ACK), .A_ERR(fA_ERR), .A_RD(fA_RD),
        .B_REQ(fB_REQ), .B_ADDR(fB_ADDR), .B_RW(1'b0), .B_WD(32'h0),
        .B_ACK(fB_ACK), .B_ERR(fB_ERR), .B_RD(fB_RD),
        .MEM_ADDR(fMEM_ADDR), .MEM_RW(fMEM_RW), .MEM_WD(fMEM_WD), .MEM_RD(fMEM_ADDR)
    );

    // Memory behind the main DUT; a marker pattern stands in for the floating bus on writes.
    logic [31:0] mem [0:1023];
    logic [31:0] model_mem [0:1023];
    assign MEM_RD = MEM_RW ? 32'hBAD0_BAD0 : mem[MEM_ADDR[11:2]];
    always @(posedge CLK) if (MEM_RW) mem[MEM_ADDR[11:2]] <= MEM_WD;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wd;
    } txn_t;

    txn_t        qa[$], qb[$];
    int          ack_port[$], ack_cyc[$];
    int          n_cmp = 0, n_bad = 0;
    int          acks_a = 0, acks_b = 0, rw_seen = 0;
    int          last_ack_a = 0, last_ack_b = 0;
    logic [31:0] exp_rd_a = '0, exp_rd_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: the reference is a flat memory array updated in ack order,
    // plus the rule "out of range -> ERR, RD=0, no write; write -> RD held".
    task automatic score(input int p, input logic err, input logic [31:0] rd);
        txn_t t;
        logic exp_err;
        logic [31:0] exp_rd;
        if (p == 0 ? qa.size() == 0 : qb.size() == 0) begin
            check(p == 0 ? "A_unexpected_ack" : "B_unexpected_ack", 32'd1, 32'd0);
            return;
        end
        t = (p == 0) ? qa.pop_front() : qb.pop_front();
        exp_rd  = (p == 0) ? exp_rd_a : exp_rd_b;
        exp_err = !(t.addr < 32'd4096);
        if (exp_err) exp_rd = '0;
        else if (!t.rw) exp_rd = model_mem[t.addr[11:2]];
        else model_mem[t.addr[11:2]] = t.wd;
        if (p == 0) exp_rd_a = exp_rd; else exp_rd_b = exp_rd;
        check(p == 0 ? "A_ERR" : "B_ERR", {31'd0, err}, {31'd0, exp_err});
        check(p == 0 ? "A_RD" : "B_RD", rd, exp_rd);
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (MEM_RW) rw_seen++;
            if (A_ACK || B_ACK) check("ack_exclusive", {31'd0, A_ACK && B_ACK}, 32'd0);
            if (A_ERR && !A_ACK) check("A_ERR_without_ack", 32'd1, 32'd0);
            if (B_ERR && !B_ACK) check("B_ERR_without_ack", 32'd1, 32'd0);
            if (A_ACK) begin
                acks_a++; last_ack_a = cyc; ack_port.push_back(0); ack_cyc.push_back(cyc);
                score(0, A_ERR, A_RD);
            end
            if (B_ACK) begin
                acks_b++; last_ack_b = cyc; ack_port.push_back(1); ack_cyc.push_back(cyc);
                score(1, B_ERR, B_RD);
            end
        end
    end

    // Caller is aligned to posedge+#1. Returns ack latency in cycles (-1 on timeout).
    task automatic do_txn(input int p, input logic [31:0] addr, input logic rw,
                          input logic [31:0] wd, output int lat);
        txn_t t;
        int   start, n0, k;
        t.addr = addr; t.rw = rw; t.wd = wd;
        start = cyc;
        if (p == 0) begin
            qa.push_back(t); A_REQ = 1'b1; A_ADDR = addr; A_RW = rw; A_WD = wd; n0 = acks_a;
        end else begin
            qb.push_back(t); B_REQ = 1'b1; B_ADDR = addr; B_RW = rw; B_WD = wd; n0 = acks_b;
        end
        k = 0;
        while (((p == 0) ? acks_a : acks_b) == n0 && k < 40) begin
            @(posedge CLK); #1; k++;
        end
        if (((p == 0) ? acks_a : acks_b) == n0) begin
            check(p == 0 ? "A_ack_timeout" : "B_ack_timeout", 32'd0, 32'd1);
            if (p == 0) void'(qa.pop_back()); else void'(qb.pop_back());
            lat = -1;
        end else begin
            lat = ((p == 0) ? last_ack_a : last_ack_b) - start;
        end
        if (p == 0) A_REQ = 1'b0; else B_REQ = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1; A_REQ = 1'b0; B_REQ = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b0;
        exp_rd_a = '0; exp_rd_b = '0;
        qa.delete(); qb.delete();
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return (32'($urandom_range(1, 32'hFFFFF)) << 12) | 32'($urandom_range(0, 4095));
        return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] <= 32'(i);
            model_mem[i] = 32'(i);
        end
    end

    initial begin
        int lat, b0, rw0, first, second, last_b;
        logic [31:0] pre;

        @(posedge CLK); #1;
        @(posedge CLK); #1;
        // Reset state
        check("rst_A_ACK", {31'd0, A_ACK}, 32'd0);
        check("rst_B_ACK", {31'd0, B_ACK}, 32'd0);
        check("rst_A_RD", A_RD, 32'd0);
        check("rst_B_RD", B_RD, 32'd0);
        check("rst_MEM_ADDR", MEM_ADDR, 32'd0);
        check("rst_MEM_RW", {31'd0, MEM_RW}, 32'd0);
        RST = 1'b0;

        // Simultaneous requests from reset: A first, then B; repeat gives B first.
        ack_port.delete(); ack_cyc.delete();
        fork
            begin int l; do_txn(0, 32'h0, 1'b0, 32'h0, l); end
            begin int l; do_txn(1, 32'h4, 1'b0, 32'h0, l); end
        join
        check("rr1_first_is_A", 32'(ack_port[0]), 32'd0);
        check("rr1_second_is_B", 32'(ack_port[1]), 32'd1);
        check("rr1_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd2);
        ack_port.delete(); ack_cyc.delete();
        fork
            begin int l; do_txn(0, 32'h8, 1'b0, 32'h0, l); end
            begin int l; do_txn(1, 32'hC, 1'b0, 32'h0, l); end
        join
        check("rr2_first_is_B", 32'(ack_port[0]), 32'd1);
        check("rr2_second_is_A", 32'(ack_port[1]), 32'd0);

        // Single read, latency and data
        b0 = acks_b;
        do_txn(0, 32'h8, 1'b0, 32'h0, lat);
        check("read_latency", 32'(lat), 32'd2);
        check("read_A_RD", A_RD, 32'd2);
        check("read_no_B_ack", 32'(acks_b), 32'(b0));

        // B write then A read back
        do_txn(1, 32'h10, 1'b1, 32'hDEAD_BEEF, lat);
        do_txn(0, 32'h10, 1'b0, 32'h0, lat);
        check("wr_mem_word4", mem[4], 32'hDEAD_BEEF);
        check("wr_A_RD", A_RD, 32'hDEAD_BEEF);

        // Out-of-range write
        rw0 = rw_seen;
        do_txn(0, 32'h1000, 1'b1, 32'h1234_5678, lat);
        check("oor_no_MEM_RW", 32'(rw_seen - rw0), 32'd0);
        check("oor_A_RD", A_RD, 32'd0);
        check("oor_mem0_kept", mem[0], model_mem[0]);

        // Reset in the middle of a B write access
        pre = mem[5];
        b0 = acks_b;
        B_REQ = 1'b1; B_ADDR = 32'h14; B_RW = 1'b1; B_WD = 32'hCAFE_F00D;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("rst_access_MEM_RW", {31'd0, MEM_RW}, 32'd0);
        @(posedge CLK); #1;
        B_REQ = 1'b0;
        check("rst2_A_ACK", {31'd0, A_ACK}, 32'd0);
        check("rst2_B_ACK", {31'd0, B_ACK}, 32'd0);
        check("rst2_B_ERR", {31'd0, B_ERR}, 32'd0);
        check("rst2_A_RD", A_RD, 32'd0);
        check("rst2_B_RD", B_RD, 32'd0);
        check("rst2_MEM_WD", MEM_WD, 32'd0);
        RST = 1'b0; exp_rd_a = '0; exp_rd_b = '0;
        repeat (3) begin @(posedge CLK); #1; end
        check("rst_mem_unchanged", mem[5], pre);
        check("rst_no_B_ack", 32'(acks_b), 32'(b0));

        // A back-to-back, B held: alternation and bounded B latency
        ack_port.delete(); ack_cyc.delete();
        fork
            begin
                int l;
                for (int i = 0; i < 6; i++) do_txn(0, rand_addr(), 1'($urandom), $urandom, l);
            end
            begin
                int l;
                @(posedge CLK); #1;
                for (int i = 0; i < 3; i++) begin
                    do_txn(1, rand_addr(), 1'($urandom), $urandom, l);
                    check("starve_B_latency_le4", {31'd0, (l >= 0 && l <= 4)}, 32'd1);
                end
            end
        join
        last_b = -1;
        foreach (ack_port[i]) if (ack_port[i] == 1) last_b = i;
        for (int i = 0; i < last_b; i++)
            check("alternate", {31'd0, ack_port[i] != ack_port[i+1]}, 32'd1);

        // Random traffic on both ports
        fork
            begin
                int l;
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
                    do_txn(0, rand_addr(), 1'($urandom), $urandom, l);
                    check("rand_A_latency_le4", {31'd0, (l >= 0 && l <= 4)}, 32'd1);
                end
            end
            begin
                int l;
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
                    do_txn(1, rand_addr(), 1'($urandom), $urandom, l);
                    check("rand_B_latency_le4", {31'd0, (l >= 0 && l <= 4)}, 32'd1);
                end
            end
        join
        repeat (3) begin @(posedge CLK); #1; end
        check("scoreboard_A_drained", 32'(qa.size()), 32'd0);
        check("scoreboard_B_drained", 32'(qb.size()), 32'd0);
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== model_mem[i]) check("final_mem", mem[i], model_mem[i]);
        n_cmp++;

        // Fixed priority: A wins every contention
        for (int r = 0; r < 2; r++) begin
            fA_REQ = 1'b1; fA_ADDR = 32'(8 * r); fB_REQ = 1'b1; fB_ADDR = 32'(8 * r + 4);
            first = -1;
            for (int k = 0; k < 10 && first < 0; k++) begin
                @(negedge CLK);
                if (fA_ACK) first = 0; else if (fB_ACK) first = 1;
            end
            @(posedge CLK); #1;
            if (first == 0) fA_REQ = 1'b0; else fB_REQ = 1'b0;
            second = -1;
            for (int k = 0; k < 10 && second < 0; k++) begin
                @(negedge CLK);
                if (fA_ACK) second = 0; else if (fB_ACK) second = 1;
            end
            @(posedge CLK); #1;
            fA_REQ = 1'b0; fB_REQ = 1'b0;
            check("fixed_first_is_A", 32'(first), 32'd0);
            check("fixed_second_is_B", 32'(second), 32'd1);
            check("fixed_A_RD", fA_RD, 32'(8 * r));
            check("fixed_B_RD", fB_RD, 32'(8 * r + 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
